// File: rtl/button_pulser.sv
// Synchronizes, debounces and edge-detects the set/up/down push-buttons into one-cycle strobes.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-auto-repeat on up/down.
module button_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_PERIOD   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_up,
  input  logic btn_down,
  input  logic enable,
  output logic pulsed_set,
  output logic pulsed_up,
  output logic pulsed_down,
  output logic held_up,
  output logic held_down
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("button_pulser: all cycle parameters must be >= 2");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = set, bit 1 = up, bit 2 = down.
  logic [2:0]      btn;
  logic [2:0]      s1_q, s2_q;
  logic [2:0]      stable_q, stable_d;
  logic [2:0]      rise;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic [1:0]      rep_fire;
  logic            up_raw, down_raw, conflict;

  assign btn = {btn_down, btn_up, btn_set};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign rise = stable_d & ~stable_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= btn;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcntW  = $clog2(RepMax);
  localparam logic [RcntW-1:0] DelayMax  = RcntW'(REPEAT_DELAY - 1);
  localparam logic [RcntW-1:0] PeriodMax = RcntW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StHoldWait, StRepeat} rep_state_e;

  // Index 0 = up, 1 = down.
  rep_state_e       state_q [2];
  logic [RcntW-1:0] rcnt_q  [2];

  // Keyed on the next stable level so a repeat can never coincide with the release edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 2; j++) begin
        state_q[j] <= StIdle;
        rcnt_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!stable_d[j+1]) begin
          state_q[j] <= StIdle;
          rcnt_q[j]  <= '0;
        end else begin
          unique case (state_q[j])
            StIdle: begin
              if (rise[j+1]) begin
                state_q[j] <= StHoldWait;
                rcnt_q[j]  <= '0;
              end
            end
            StHoldWait: begin
              if (rcnt_q[j] == DelayMax) begin
                state_q[j] <= StRepeat;
                rcnt_q[j]  <= '0;
              end else begin
                rcnt_q[j] <= rcnt_q[j] + RcntW'(1);
              end
            end
            StRepeat: begin
              if (rcnt_q[j] == PeriodMax) begin
                rcnt_q[j] <= '0;
              end else begin
                rcnt_q[j] <= rcnt_q[j] + RcntW'(1);
              end
            end
            default: begin
              state_q[j] <= StIdle;
              rcnt_q[j]  <= '0;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rep_fire[j] = stable_d[j+1] &&
                    (((state_q[j] == StHoldWait) && (rcnt_q[j] == DelayMax)) ||
                     ((state_q[j] == StRepeat) && (rcnt_q[j] == PeriodMax)));
    end
  end
`else
  assign rep_fire = 2'b00;
`endif

  assign up_raw   = rise[1] | rep_fire[0];
  assign down_raw = rise[2] | rep_fire[1];
  assign conflict = up_raw & down_raw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pulsed_set  <= 1'b0;
      pulsed_up   <= 1'b0;
      pulsed_down <= 1'b0;
    end else begin
      pulsed_set  <= enable & rise[0];
      pulsed_up   <= enable & up_raw & ~conflict;
      pulsed_down <= enable & down_raw & ~conflict;
    end
  end

  assign held_up   = stable_q[1];
  assign held_down = stable_q[2];

endmodule

// File: doc/button_pulser.md
Name: button_pulser

Overview:
- Front-end conditioning stage that feeds the 12-hour clock/setter top level.
- Takes raw, bouncing, asynchronous push-button levels (set, up, down).
- Produces the single-cycle `pulsed_set`, `pulsed_up` and `pulsed_down` strobes the setter consumes, all in the `clk` domain.
- Up/down gain hold-to-auto-repeat so the user can sweep minutes quickly.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive `clk` cycles the synchronized input must differ from the accepted level before the change is accepted (≥2).
- REPEAT_DELAY, 10, cycles up/down must stay held after the press pulse before the first repeat pulse (≥2).
- REPEAT_PERIOD, 3, cycles between successive repeat pulses while held (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-low
- btn_set  input  1  raw set button, active-high, asynchronous
- btn_up  input  1  raw up button, active-high, asynchronous
- btn_down  input  1  raw down button, active-high, asynchronous
- enable  input  1  strobe enable; debouncing runs regardless
- pulsed_set  output  1  one-cycle strobe per accepted set press
- pulsed_up  output  1  one-cycle strobe per up press or repeat
- pulsed_down  output  1  one-cycle strobe per down press or repeat
- held_up  output  1  debounced up level
- held_down  output  1  debounced down level

Behaviour:
- Reset: on any `clk` rising edge with `reset`=0, clear all synchronizer FFs, stable levels, counters, FSMs and all outputs to 0. This applies mid-operation too.
- Synchronizer: each button passes through 2 FFs (`s1`, `s2`).
- Debounce, per button:
  - `cnt` increments while `s2` != `stable`, and clears to 0 when they are equal.
  - When `cnt` == DEBOUNCE_CYCLES-1 and `s2` != `stable`: `stable` <= `s2`, `cnt` <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored completely.
- Press pulse:
  - Raw `pulse_raw` = 1 in the cycle `stable` transitions 0→1. It is registered, so the output goes high the same edge `stable` rises.
  - Timing: press first sampled into `s1` at edge E → strobe high for exactly the one cycle following edge E+DEBOUNCE_CYCLES+1.
  - Release (`stable` 1→0) produces no strobe.
- Repeat FSM (up and down each have their own; set has none). States IDLE, HOLD_WAIT, REPEAT:
  - IDLE→HOLD_WAIT on the press pulse; load `rcnt`=0.
  - HOLD_WAIT: `rcnt` increments each cycle. When `rcnt` == REPEAT_DELAY-1, emit one repeat strobe, go to REPEAT, `rcnt`=0.
  - REPEAT: when `rcnt` == REPEAT_PERIOD-1, emit a strobe and set `rcnt`=0.
  - From any state, `stable`=0 → IDLE the next edge. No strobe is issued on that edge.
- Conflict rule: if up and down strobes would assert in the same cycle, both are suppressed for that cycle. Their FSMs still advance. `pulsed_set` is unaffected by this rule.
- `enable`=0: all three strobes forced 0. Debounce and FSM state still advance, so a press made while disabled is lost and is not replayed.
- `held_up` / `held_down` = registered `stable` levels.
- A button held through reset release is treated as a new press: it strobes once debounced.
- Strobes are never wider than 1 cycle.
- Repeat pulses are only ever emitted after the initial press pulse has been emitted.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: repeat FSMs present, behaviour as above.
- Undefined: the FSMs and `rcnt` are not compiled. `pulsed_up` / `pulsed_down` carry only press pulses, exactly one per debounced press regardless of hold time. Conflict rule and `enable` gating still apply.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, `enable`=1, macro defined unless noted):
- Clean set press: `btn_set` rises before edge 1, held 30 cycles → `pulsed_set` high only in the cycle after edge 6, then 0. No pulse on release.
- Bounce: `btn_up` toggles 1,0,1,0 on single cycles, then steady 1 → exactly one `pulsed_up`, 6 edges after the steady level is first sampled. `held_up` rises in that same cycle.
- Auto-repeat: `btn_down` held 40 cycles → press strobe at cycle P, repeat strobes at P+10, P+13, P+16, … Release → no further strobes after `held_down` falls.
- Repeat disabled: the same 40-cycle hold with macro undefined → exactly one `pulsed_down`.
- Conflict/enable:
  - up and down pressed in the same cycle → neither strobes, and both `held_*`=1.
  - Set pressed while `enable`=0 → no `pulsed_set`, even after `enable` returns to 1.
- Reset mid-hold: `reset`=0 for 1 cycle during REPEAT → all outputs 0 next cycle. With the button still held, a new press strobe follows 6 edges after release of reset.
